// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synchronises and debounces four push-buttons, then once per
// frame (start of vertical blanking) steps the sprite origin, clamped to the visible area.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// WAIT_FRAME | idle, waiting for the registered frame tick
// LATCH      | capture debounced buttons into the command register
// APPLY      | compute clamped next X/Y into the holding registers
// PUBLISH    | load sprite origin outputs, pulse Pos_Update_Out
module sprite_motion_ctrl #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int SPRITE_W        = 32,
    parameter int SPRITE_H        = 32,
    parameter int STEP            = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int X_INIT          = 304,
    parameter int Y_INIT          = 224
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic [9:0] Val_Col_In,
    input  logic [9:0] Val_Row_In,
    output logic [9:0] Sprite_X_Out,
    output logic [9:0] Sprite_Y_Out,
    output logic       Pos_Update_Out,
    output logic [3:0] Btn_State_Out
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [10:0]     X_MAX    = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0]     Y_MAX    = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0]     STEP_11  = 11'(STEP);
    localparam logic [9:0]      STEP_10  = 10'(STEP);
    localparam logic [9:0]      ROW_TICK = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        LATCH,
        APPLY,
        PUBLISH
    } state_t;

    state_t           state;
    logic [3:0]       raw_btn;
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [CNT_W-1:0] deb_cnt [4];
    logic             tick_cond;
    logic             tick_cond_d;
    logic             tick_q;
    logic [3:0]       cmd;
    logic [9:0]       x_hold;
    logic [9:0]       y_hold;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic [10:0]      x_sum;
    logic [10:0]      y_sum;

    // Bit order matches Btn_State_Out: {Up, Down, Left, Right}
    assign raw_btn   = {Up, Down, Left, Right};
    assign tick_cond = (Val_Row_In == ROW_TICK) && (Val_Col_In == 10'd0);

    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            sync_1        <= '0;
            sync_2        <= '0;
            Btn_State_Out <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync_1 <= raw_btn;
            sync_2 <= sync_1;
            for (int i = 0; i < 4; i++) begin
                if (sync_2[i] == Btn_State_Out[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    Btn_State_Out[i] <= sync_2[i];
                    deb_cnt[i]       <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising-edge detect so a multi-cycle match on the tick position still fires once
    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            tick_cond_d <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_cond_d <= tick_cond;
            tick_q      <= tick_cond & ~tick_cond_d;
        end
    end

    always_comb begin
        x_sum  = {1'b0, Sprite_X_Out} + STEP_11;
        y_sum  = {1'b0, Sprite_Y_Out} + STEP_11;
        x_next = Sprite_X_Out;
        y_next = Sprite_Y_Out;
        if (cmd[0] && !cmd[1]) begin
            x_next = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
        end else if (cmd[1] && !cmd[0]) begin
            x_next = (Sprite_X_Out < STEP_10) ? 10'd0 : Sprite_X_Out - STEP_10;
        end
        if (cmd[2] && !cmd[3]) begin
            y_next = (y_sum > Y_MAX) ? Y_MAX[9:0] : y_sum[9:0];
        end else if (cmd[3] && !cmd[2]) begin
            y_next = (Sprite_Y_Out < STEP_10) ? 10'd0 : Sprite_Y_Out - STEP_10;
        end
    end

    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            state          <= WAIT_FRAME;
            cmd            <= '0;
            x_hold         <= 10'(X_INIT);
            y_hold         <= 10'(Y_INIT);
            Sprite_X_Out   <= 10'(X_INIT);
            Sprite_Y_Out   <= 10'(Y_INIT);
            Pos_Update_Out <= 1'b0;
        end else begin
            Pos_Update_Out <= 1'b0;
            case (state)
                WAIT_FRAME: begin
                    if (tick_q) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    cmd   <= Btn_State_Out;
                    state <= APPLY;
                end
                APPLY: begin
                    x_hold <= x_next;
                    y_hold <= y_next;
                    state  <= PUBLISH;
                end
                PUBLISH: begin
                    Sprite_X_Out   <= x_hold;
                    Sprite_Y_Out   <= y_hold;
                    Pos_Update_Out <= 1'b1;
                    state          <= WAIT_FRAME;
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: cycle-level behavioural model plus directed and random stimulus
// on a shortened raster scan (80 cycles per frame).
module tb_sprite_motion_ctrl;

    localparam int DEB   = 4;
    localparam int H     = 640;
    localparam int V     = 480;
    localparam int SW    = 32;
    localparam int SH    = 32;
    localparam int STEP  = 4;
    localparam int XI    = 304;
    localparam int YI    = 224;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [9:0] col, row;
    logic [9:0] sprite_x, sprite_y;
    logic       pos_update;
    logic [3:0] btn_state;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SPRITE_W(SW), .SPRITE_H(SH), .STEP(STEP),
        .DEBOUNCE_CYCLES(DEB), .X_INIT(XI), .Y_INIT(YI)
    ) dut (
        .Master_Clock_In(clk),
        .Reset_N_In(rst_n),
        .Up(up),
        .Down(down),
        .Left(left),
        .Right(right),
        .Val_Col_In(col),
        .Val_Row_In(row),
        .Sprite_X_Out(sprite_x),
        .Sprite_Y_Out(sprite_y),
        .Pos_Update_Out(pos_update),
        .Btn_State_Out(btn_state)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         model_valid = 0;
    int         cyc = 0;
    int         sched_k = -1;       // cycle of the accepted tick edge, -1 when idle
    int         m_x = XI, m_y = YI;
    bit         m_pulse = 0;
    bit [3:0]   m_btn = 0;
    bit [3:0]   m_cmd = 0;
    bit         m_prev_tc = 0;
    bit [3:0]   hist [0:DEB+1];     // raw button samples, hist[0] newest

    always @(posedge clk) begin
        bit       tc;
        bit       same;
        bit       v;
        bit [3:0] stable_before;
        cyc++;
        if (!rst_n) begin
            model_valid = 1;
            m_x = XI;
            m_y = YI;
            m_pulse = 0;
            m_btn = 0;
            m_cmd = 0;
            m_prev_tc = 0;
            sched_k = -1;
            for (int i = 0; i <= DEB + 1; i++) hist[i] = 0;
        end else begin
            stable_before = m_btn;
            m_pulse = 0;
            if (sched_k >= 0 && cyc == sched_k + 2) m_cmd = stable_before;
            if (sched_k >= 0 && cyc == sched_k + 4) begin
                if (m_cmd[0] && !m_cmd[1]) m_x = (m_x + STEP < H - SW) ? m_x + STEP : H - SW;
                if (m_cmd[1] && !m_cmd[0]) m_x = (m_x - STEP > 0) ? m_x - STEP : 0;
                if (m_cmd[2] && !m_cmd[3]) m_y = (m_y + STEP < V - SH) ? m_y + STEP : V - SH;
                if (m_cmd[3] && !m_cmd[2]) m_y = (m_y - STEP > 0) ? m_y - STEP : 0;
                m_pulse = 1;
                sched_k = -1;
            end
            tc = (row == 10'(V)) && (col == 10'd0);
            if (tc && !m_prev_tc && sched_k < 0) sched_k = cyc;
            m_prev_tc = tc;
            for (int i = DEB + 1; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = {up, down, left, right};
            // accept a level once the synchronised input has shown it for DEB consecutive samples
            for (int b = 0; b < 4; b++) begin
                v = hist[2][b];
                same = 1;
                for (int i = 2; i <= DEB + 1; i++) if (hist[i][b] != v) same = 0;
                if (same && v != m_btn[b]) m_btn[b] = v;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("sprite_x", sprite_x, m_x);
            check("sprite_y", sprite_y, m_y);
            check("pos_update", pos_update, m_pulse);
            check("btn_state", btn_state, m_btn);
        end
    end

    // ---------------- raster scan ----------------
    bit stall_en = 0;
    bit jump_en = 0;

    initial begin
        row = 10'd476;
        col = 10'd1;
        forever begin
            @(negedge clk);
            if (jump_en && $urandom_range(299) == 0) begin
                row = 10'(V);
                col = 10'd0;
            end else if (!stall_en || $urandom_range(3) != 0) begin
                if (col == 10'd9) begin
                    col = 10'd0;
                    row = (row == 10'd483) ? 10'd476 : row + 10'd1;
                end else begin
                    col = col + 10'd1;
                end
            end
        end
    end

    task automatic wait_pulse();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (pos_update) seen = 1;
        end
        if (!seen) check("pulse_timeout", 0, 1);
    endtask

    task automatic set_btn(input bit [3:0] b);
        {up, down, left, right} = b;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        bit       found;
        bit [3:0] drv;

        rst_n = 1'b0;
        set_btn(4'b0000);
        repeat (3) @(negedge clk);
        check("rst_x", sprite_x, 304);
        check("rst_y", sprite_y, 224);
        check("rst_pulse", pos_update, 0);
        check("rst_btn", btn_state, 0);
        rst_n = 1'b1;

        wait_pulse();
        check("first_frame_x", sprite_x, 304);
        check("first_frame_y", sprite_y, 224);

        // glitch shorter than the debounce window
        right = 1'b1;
        repeat (3) @(negedge clk);
        right = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_btn", btn_state, 0);
        right = 1'b1;
        repeat (10) @(negedge clk);
        check("held_btn", btn_state, 1);

        wait_pulse();
        check("move_x1", sprite_x, 308);
        wait_pulse();
        check("move_x2", sprite_x, 312);
        wait_pulse();
        check("move_x3", sprite_x, 316);
        check("move_y", sprite_y, 224);

        set_btn(4'b0010);
        repeat (85) wait_pulse();
        check("clamp_left", sprite_x, 0);

        set_btn(4'b0100);
        repeat (60) wait_pulse();
        check("clamp_down", sprite_y, 448);

        set_btn(4'b1101);
        wait_pulse();
        wait_pulse();
        check("conflict_v_x", sprite_x, 8);
        check("conflict_v_y", sprite_y, 448);

        set_btn(4'b1011);
        wait_pulse();
        wait_pulse();
        check("conflict_h_x", sprite_x, 8);
        check("conflict_h_y", sprite_y, 440);

        // reset landing on the APPLY cycle
        set_btn(4'b0001);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            if (row == 10'(V) && col == 10'd0) found = 1;
        end
        if (!found) check("tick_timeout", 0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_x", sprite_x, 304);
        check("abort_y", sprite_y, 224);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_pulse", pos_update, 0);
        end
        wait_pulse();
        check("resume_x", sprite_x, 308);
        check("resume_y", sprite_y, 224);

        // random phase
        stall_en = 1;
        jump_en = 1;
        drv = 4'b0000;
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) drv[$urandom_range(3)] = ~drv[$urandom_range(3)];
            if ($urandom_range(15) == 0) drv = 4'($urandom_range(15));
            set_btn(drv);
            rst_n = ($urandom_range(2999) != 0);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
